// File: rtl/ms_beat_sequencer_pkg.sv
// Shared definitions for the main-store beat sequencer: beat state encoding
// and the digit positions that derive from the beat length.
package ms_beat_sequencer_pkg;

   typedef enum logic {
      ST_SCAN   = 1'b0,
      ST_ACTION = 1'b1
   } beat_state_t;

   function automatic int beat_len(input int instr_bits, input int flyback_time);
      return instr_bits + flyback_time;
   endfunction

   // The write strobe sits on the final digit of the beat.
   function automatic int xtb_digit(input int blen);
      return blen - 1;
   endfunction

   // The acknowledge leads the boundary by one digit so the CPU can react in time.
   function automatic int ack_digit(input int blen);
      return blen - 2;
   endfunction

   function automatic int digit_width(input int range_n);
      return (range_n <= 2) ? 1 : $clog2(range_n);
   endfunction

endpackage

// File: rtl/ms_digit_counter.sv
// Mod-BEAT_LEN digit counter; flags the first digit (beat boundary decision)
// and the last digit (store write strobe) of every beat.
module ms_digit_counter
   import ms_beat_sequencer_pkg::*;
#(
   parameter int BEAT_LEN = 24,
   parameter int DW       = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic [DW-1:0] digit,
   output logic          first_digit,
   output logic          last_digit
);

   localparam logic [DW-1:0] LAST = DW'(xtb_digit(BEAT_LEN));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit <= '0;
      end else if (digit == LAST) begin
         digit <= '0;
      end else begin
         digit <= digit + DW'(1);
      end
   end

   assign first_digit = (digit == '0);
   assign last_digit  = (digit == LAST);

endmodule

// File: rtl/ms_beat_sequencer.sv
// Beat-level arbiter for the serial main store: grants each beat to a CPU
// access or to regeneration of the next line, and drives store control.
module ms_beat_sequencer
   import ms_beat_sequencer_pkg::*;
#(
   parameter int INSTR_BITS      = 20,
   parameter int INSTR_ADDR_BITS = 10,
   parameter int FLYBACK_TIME    = 4,
   parameter int MAX_ACTION_RUN  = 3
) (
   input  logic                       w_DPG,
   input  logic                       w_RST_N,
   input  logic                       w_CPU_REQ,
   input  logic [INSTR_ADDR_BITS-1:0] b_CPU_ADDR,
   input  logic                       w_CPU_WR,
   input  logic                       w_STOP,
   output logic [INSTR_ADDR_BITS-1:0] b_MS_ADDR,
   output logic                       w_XTB,
   output logic                       w_MS_ZERO,
   output logic                       w_CPU_ACK,
   output logic                       w_CPU_RD_WIN,
   output logic                       w_BEAT_START,
   output logic                       w_ACTION
);

   localparam int BEAT_LEN = beat_len(INSTR_BITS, FLYBACK_TIME);
   localparam int DW       = digit_width(BEAT_LEN);
   localparam int RW       = digit_width(MAX_ACTION_RUN + 1);
   localparam int AW       = INSTR_ADDR_BITS;

   localparam logic [DW-1:0] ACK_D   = DW'(ack_digit(BEAT_LEN));
   localparam logic [DW-1:0] RD_LO   = DW'(1);
   localparam logic [DW-1:0] RD_HI   = DW'(INSTR_BITS);
   localparam logic [RW-1:0] RUN_MAX = RW'(MAX_ACTION_RUN);

   // Handshake: the CPU holds w_CPU_REQ with stable b_CPU_ADDR/w_CPU_WR until
   // w_CPU_ACK pulses; each ACK pulse completes exactly one access beat.

   logic [DW-1:0] digit;
   logic          boundary;
   logic          last_digit;

   beat_state_t   state;
   beat_state_t   nxt_state;
   logic          first_beat;
   logic          wr_lat;
   logic          nxt_wr;
   logic          grant;
   logic [RW-1:0] run_cnt;
   logic [AW-1:0] regen_addr;
   logic [AW-1:0] regen_nxt;

   ms_digit_counter #(
      .BEAT_LEN (BEAT_LEN),
      .DW       (DW)
   ) u_digit_counter (
      .clk         (w_DPG),
      .rst_n       (w_RST_N),
      .digit       (digit),
      .first_digit (boundary),
      .last_digit  (last_digit)
   );

   // Outputs are decoded from the counter one digit ahead, so the boundary
   // decision is taken on the edge that ends the previous beat's last digit.
   always_comb begin
      regen_nxt = regen_addr;
      nxt_state = state;
      nxt_wr    = wr_lat;
      grant     = 1'b0;
      if (boundary) begin
         if (!first_beat && state == ST_SCAN) begin
            regen_nxt = regen_addr + AW'(1);
         end
         grant     = !first_beat && w_CPU_REQ && !w_STOP && (run_cnt < RUN_MAX);
         nxt_state = grant ? ST_ACTION : ST_SCAN;
         nxt_wr    = grant && w_CPU_WR;
      end
   end

   always_ff @(posedge w_DPG or negedge w_RST_N) begin
      if (!w_RST_N) begin
         state        <= ST_SCAN;
         first_beat   <= 1'b1;
         wr_lat       <= 1'b0;
         run_cnt      <= '0;
         regen_addr   <= '0;
         b_MS_ADDR    <= '0;
         w_XTB        <= 1'b0;
         w_MS_ZERO    <= 1'b0;
         w_CPU_ACK    <= 1'b0;
         w_CPU_RD_WIN <= 1'b0;
         w_BEAT_START <= 1'b0;
         w_ACTION     <= 1'b0;
      end else begin
         if (boundary) begin
            state      <= nxt_state;
            wr_lat     <= nxt_wr;
            first_beat <= 1'b0;
            regen_addr <= regen_nxt;
            run_cnt    <= grant ? run_cnt + RW'(1) : '0;
            b_MS_ADDR  <= grant ? b_CPU_ADDR : regen_nxt;
         end
         w_BEAT_START <= boundary;
         w_XTB        <= last_digit;
         w_ACTION     <= (nxt_state == ST_ACTION);
         w_MS_ZERO    <= (nxt_state == ST_ACTION) && nxt_wr;
         w_CPU_ACK    <= (nxt_state == ST_ACTION) && (digit == ACK_D);
         w_CPU_RD_WIN <= (nxt_state == ST_ACTION) && !nxt_wr &&
                         (digit >= RD_LO) && (digit <= RD_HI);
      end
   end

endmodule

// File: tb/tb_ms_beat_sequencer.sv
// Bench for ms_beat_sequencer: beat-level reference model feeds an expected
// queue; a monitor captures each observed beat and compares it.
module tb_ms_beat_sequencer;

   localparam int IB = 20;
   localparam int AW = 4;
   localparam int FB = 4;
   localparam int MR = 3;
   localparam int BL = IB + FB;
   localparam int EW = AW + 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cpu_req = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic          cpu_wr = 1'b0;
   logic          stop = 1'b0;
   logic [AW-1:0] ms_addr;
   logic          xtb, ms_zero, cpu_ack, rd_win, beat_start, action;

   logic [EW-1:0] exp_q[$];
   int            n_cmp = 0;
   int            n_fail = 0;
   int            beats_checked = 0;

   always #5 clk = ~clk;

   ms_beat_sequencer #(
      .INSTR_BITS      (IB),
      .INSTR_ADDR_BITS (AW),
      .FLYBACK_TIME    (FB),
      .MAX_ACTION_RUN  (MR)
   ) dut (
      .w_DPG        (clk),
      .w_RST_N      (rst_n),
      .w_CPU_REQ    (cpu_req),
      .b_CPU_ADDR   (cpu_addr),
      .w_CPU_WR     (cpu_wr),
      .w_STOP       (stop),
      .b_MS_ADDR    (ms_addr),
      .w_XTB        (xtb),
      .w_MS_ZERO    (ms_zero),
      .w_CPU_ACK    (cpu_ack),
      .w_CPU_RD_WIN (rd_win),
      .w_BEAT_START (beat_start),
      .w_ACTION     (action)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: one decision per beat, counted in cycles since reset.
   initial begin
      int            cyc;
      bit            first;
      bit            prev_action;
      int            run;
      int            regen;
      logic [EW-1:0] e;
      cyc = 0; first = 1; prev_action = 0; run = 0; regen = 0;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            cyc = 0; first = 1; prev_action = 0; run = 0; regen = 0;
            exp_q.delete();
         end else begin
            if (cyc % BL == 0) begin
               if (first) begin
                  first = 0;
                  e = {1'b0, 1'b0, AW'(regen)};
               end else begin
                  if (!prev_action) regen = (regen + 1) % (1 << AW);
                  if (cpu_req && !stop && run < MR) begin
                     run++;
                     prev_action = 1;
                     e = {1'b1, cpu_wr, cpu_addr};
                  end else begin
                     run = 0;
                     prev_action = 0;
                     e = {1'b0, 1'b0, AW'(regen)};
                  end
               end
               exp_q.push_back(e);
            end
            cyc++;
         end
      end
   end

   // Monitor: capture a full beat starting at w_BEAT_START, then compare.
   initial begin
      bit            collecting;
      int            idx;
      logic [AW-1:0] addr0;
      bit            addr_ok;
      logic [BL-1:0] xtb_m, ack_m, rd_m, zero_m, start_m, act_m;
      logic [BL-1:0] all_m, rd_exp;
      logic [EW-1:0] e;
      all_m  = '1;
      rd_exp = BL'(((1 << IB) - 1) << 1);
      collecting = 0; idx = 0; addr0 = '0; addr_ok = 1;
      xtb_m = '0; ack_m = '0; rd_m = '0; zero_m = '0; start_m = '0; act_m = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            check("reset_outputs", 32'({ms_addr, xtb, ms_zero, cpu_ack, rd_win, beat_start, action}), 32'd0);
            collecting = 0;
         end else begin
            if (!collecting && beat_start) begin
               collecting = 1; idx = 0; addr0 = ms_addr; addr_ok = 1;
               xtb_m = '0; ack_m = '0; rd_m = '0; zero_m = '0; start_m = '0; act_m = '0;
            end
            if (collecting) begin
               xtb_m[idx] = xtb; ack_m[idx] = cpu_ack; rd_m[idx] = rd_win;
               zero_m[idx] = ms_zero; start_m[idx] = beat_start; act_m[idx] = action;
               if (ms_addr !== addr0) addr_ok = 0;
               if (idx == BL - 1) begin
                  collecting = 0;
                  beats_checked++;
                  if (exp_q.size() == 0) begin
                     n_cmp++; n_fail++;
                     $display("FAIL exp_underflow: beat observed at t=%0t, expected none", $time);
                  end else begin
                     e = exp_q.pop_front();
                     check("ms_addr", 32'(addr0), 32'(e[AW-1:0]));
                     check("addr_stable", 32'(addr_ok), 32'd1);
                     check("action_mask", 32'(act_m), e[AW+1] ? 32'(all_m) : 32'd0);
                     check("zero_mask", 32'(zero_m), (e[AW+1] && e[AW]) ? 32'(all_m) : 32'd0);
                     check("xtb_mask", 32'(xtb_m), 32'd1 << (BL - 1));
                     check("ack_mask", 32'(ack_m), e[AW+1] ? (32'd1 << (BL - 2)) : 32'd0);
                     check("rdwin_mask", 32'(rd_m), (e[AW+1] && !e[AW]) ? 32'(rd_exp) : 32'd0);
                     check("start_mask", 32'(start_m), 32'd1);
                  end
               end else begin
                  idx++;
               end
            end
         end
      end
   end

   task automatic wait_ack();
      bit ok;
      ok = 0;
      for (int i = 0; i < 8 * BL; i++) begin
         @(negedge clk);
         if (cpu_ack) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         n_cmp++; n_fail++;
         $display("FAIL ack_timeout: no ack within %0d cycles, expected one", 8 * BL);
      end
   endtask

   task automatic wait_action_start();
      bit ok;
      ok = 0;
      for (int i = 0; i < 8 * BL; i++) begin
         @(negedge clk);
         if (action && beat_start) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         n_cmp++; n_fail++;
         $display("FAIL action_timeout: no action beat within %0d cycles, expected one", 8 * BL);
      end
   endtask

   task automatic do_access(input logic [AW-1:0] a, input logic wr, input bit keep);
      cpu_req  = 1'b1;
      cpu_addr = a;
      cpu_wr   = wr;
      wait_ack();
      if (!keep) cpu_req = 1'b0;
   endtask

   initial begin
      bit keep;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Idle scanning, then a directed read and write.
      repeat (5 * BL) @(negedge clk);
      repeat (7) @(negedge clk);
      do_access(AW'(5), 1'b0, 1'b0);
      repeat (BL + 3) @(negedge clk);
      do_access(AW'(7), 1'b1, 1'b0);
      repeat (BL) @(negedge clk);

      // Back-to-back requests exercise the forced scan after MR actions.
      for (int i = 0; i < 7; i++) do_access(AW'(i + 1), ((i % 2) == 1), (i < 6));
      repeat (BL) @(negedge clk);

      // STOP raised during an action beat: beat completes, then scans only.
      cpu_req = 1'b1; cpu_addr = AW'(3); cpu_wr = 1'b0;
      wait_action_start();
      repeat (4) @(negedge clk);
      stop = 1'b1;
      wait_ack();
      repeat (2 * BL) @(negedge clk);
      stop = 1'b0;
      wait_ack();
      cpu_req = 1'b0;

      // Randomized traffic with occasional STOP windows.
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            stop = 1'b1;
            cpu_req = 1'($urandom_range(0, 1));
            cpu_addr = AW'($urandom_range(0, (1 << AW) - 1));
            cpu_wr = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 2 * BL)) @(negedge clk);
            stop = 1'b0;
         end
         keep = 1'($urandom_range(0, 1));
         do_access(AW'($urandom_range(0, (1 << AW) - 1)), 1'($urandom_range(0, 1)), keep);
         if (!keep) repeat ($urandom_range(0, 2 * BL)) @(negedge clk);
      end
      cpu_req = 1'b0;
      repeat (BL) @(negedge clk);

      // Reset at digit 10 of an action beat; the request is held across it.
      cpu_req = 1'b1; cpu_addr = AW'(9); cpu_wr = 1'b1;
      wait_action_start();
      repeat (10) @(negedge clk);
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_ack();
      cpu_req = 1'b0;
      repeat (3 * BL) @(negedge clk);

      check("pending_beats", 32'(exp_q.size() <= 1), 32'd1);
      check("beats_checked_min", 32'(beats_checked >= 60), 32'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/ms_beat_sequencer.md
# ms_beat_sequencer

Beat-level controller for the serial main store. Divides the digit-pulse stream into beats of INSTR_BITS+FLYBACK_TIME digits and grants each beat either to a CPU access (action beat) or to regeneration of the next store line (scan beat). It drives the store address, write strobe and zero-readout control, and returns a request/acknowledge handshake plus a read-data window to the CPU.

## Interface
- INSTR_BITS, 20: bits per store line.
- INSTR_ADDR_BITS, 10: store address width.
- FLYBACK_TIME, 4: idle digits per beat; must be ≥3.
- MAX_ACTION_RUN, 3: maximum consecutive action beats before a forced scan beat; must be ≥1.

Ports:
- w_DPG  in  1  digit pulse clock; all logic on posedge.
- w_RST_N  in  1  asynchronous active-low reset.
- w_CPU_REQ  in  1  access request; held high until w_CPU_ACK.
- b_CPU_ADDR  in  INSTR_ADDR_BITS  access address; stable while w_CPU_REQ is high.
- w_CPU_WR  in  1  1 = write, 0 = read; stable while w_CPU_REQ is high.
- w_STOP  in  1  1 = grant no further action beats; scan beats only.
- b_MS_ADDR  out  INSTR_ADDR_BITS  store line address.
- w_XTB  out  1  store write strobe.
- w_MS_ZERO  out  1  suppress readout/loopback.
- w_CPU_ACK  out  1  one-cycle access-complete pulse.
- w_CPU_RD_WIN  out  1  serial read data valid on the store output.
- w_BEAT_START  out  1  high during digit 0 of every beat.
- w_ACTION  out  1  high for the whole of an action beat.

## Operation
- BEAT_LEN = INSTR_BITS+FLYBACK_TIME. Digit counter d counts 0..BEAT_LEN-1 and wraps. Width: $clog2(BEAT_LEN).
- States: SCAN and ACTION. The state and b_MS_ADDR change only on the edge that ends digit BEAT_LEN-1, the beat boundary.
- Decision at each boundary:
  - Next beat is ACTION if w_CPU_REQ=1, w_STOP=0 and run_cnt<MAX_ACTION_RUN. Otherwise it is SCAN.
  - run_cnt increments on entering ACTION and clears on entering SCAN.
- Regeneration pointer regen_addr: INSTR_ADDR_BITS wide. Increments at the end of every SCAN beat. Wraps 2^INSTR_ADDR_BITS-1→0. Unchanged during ACTION beats.
- b_MS_ADDR is regen_addr in SCAN and the latched b_CPU_ADDR in ACTION.
- w_XTB is high during digit BEAT_LEN-1 of every beat. This regenerates the line with loopback data, or stores new data on writes.
- w_MS_ZERO is high for all digits of an ACTION beat with w_CPU_WR=1. The stored line then equals the incoming serial data only. It is low otherwise.
- w_CPU_RD_WIN is high for digits 1..INSTR_BITS of an ACTION read beat. Bit k is valid at digit k+1.
- w_CPU_ACK is high during digit BEAT_LEN-2 of every ACTION beat. The CPU either drops the request or presents the next one before the boundary edge, so back-to-back actions are possible.
- The w_CPU_WR/b_CPU_ADDR values latched at the boundary govern the whole beat. Input changes mid-beat are ignored.

## Timing
- All outputs are registered.
- Reset values: b_MS_ADDR=0, w_XTB=0, w_MS_ZERO=0, w_CPU_ACK=0, w_CPU_RD_WIN=0, w_BEAT_START=0, w_ACTION=0. Internal reset values: state=SCAN, d=0, regen_addr=0, run_cnt=0.
- First cycle after reset release:
  - Digit 0 of a SCAN beat at address 0.
  - w_BEAT_START is asserted from the first edge after release.
- Grant latency: a request first seen at the boundary edge starts action at the next digit 0. A request raised mid-beat waits for the next boundary.
- Simultaneous w_CPU_REQ and forced scan (run_cnt=MAX_ACTION_RUN): scan wins; the request is granted at the following boundary.
- w_STOP asserted mid-ACTION: the current beat completes, including ACK. Subsequent beats are SCAN.
- Reset mid-beat:
  - The beat is aborted immediately, with no w_XTB and no w_CPU_ACK.
  - The CPU must re-request.

## Structure
- Shared package holds:
  - state encoding: SCAN, ACTION;
  - BEAT_LEN derived from INSTR_BITS and FLYBACK_TIME;
  - the digit indices for the XTB and ACK digits.
- One sub-module, ms_digit_counter: the mod-BEAT_LEN counter that emits beat-start and last-digit strobes. The arbitration FSM and regen pointer stay in ms_beat_sequencer.

## Test plan
- Reset: hold w_RST_N low mid-beat → all outputs 0. After release, b_MS_ADDR=0 and w_BEAT_START=1.
- Idle scan, INSTR_ADDR_BITS=2: no requests for 5 beats → b_MS_ADDR sequence 0,1,2,3,0. w_XTB is high only at digit 23 of each beat.
- Read addr 5: request in SCAN beat → next beat has b_MS_ADDR=5, w_ACTION=1, w_MS_ZERO=0, w_CPU_RD_WIN on digits 1..20, w_CPU_ACK at digit 22.
- Write addr 7: w_CPU_WR=1 → w_MS_ZERO high all 24 digits, w_XTB at digit 23, ACK at digit 22. The regen pointer is unchanged.
- Continuous requests, MAX_ACTION_RUN=3 → beats run ACTION×3, SCAN, ACTION×3. Each scan advances regen_addr by 1.
- Reset during ACTION at digit 10 → no ACK and no w_XTB. With the request held after reset release, it is granted at the boundary following the first SCAN beat.
